// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock parametrised FIFO:
// default geometry, a ceiling-log2 helper and the wrap/address pointer layout.
package fifo_pkg;

    localparam int unsigned DEF_FIFO_WIDTH = 32'd8;
    localparam int unsigned DEF_FIFO_DEPTH = 32'd64;
    localparam int unsigned DEF_ADDR_WIDTH = 32'd6;

    // Ceiling log2, used to derive the address width from the depth.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value - 32'd1;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                r = 32'(i) + 32'd1;
            end
        end
        return r;
    endfunction

    // Pointer layout for the default geometry: wrap bit above the memory address.
    typedef struct packed {
        logic                      wrap;
        logic [DEF_ADDR_WIDTH-1:0] addr;
    } fifo_ptr_t;

endpackage

// File: rtl/dpMem_sc.sv
// Single-clock simple dual-port memory: one write port, one registered read port.
// The array itself is never reset; only the read data register is.
module dpMem_sc
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [FIFO_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [FIFO_WIDTH-1:0] rdata_o
);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] rdata_q;

    // Write port: store the word at the write address.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: capture the addressed word (old contents on a same-address write), hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with exact occupancy, programmable almost
// flags and sticky overflow/underflow. Define SYNC_FIFO_FWFT_EN for
// first-word-fall-through output; otherwise reads have one cycle of latency.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_WIDTH = clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] dataIn,
    input  logic                  fifoWEn,
    input  logic                  fifoREn,
    input  logic                  forceEmpty,
    input  logic [ADDR_WIDTH:0]   afThresh,
    input  logic [ADDR_WIDTH:0]   aeThresh,
    input  logic                  clrErr,
    output logic [FIFO_WIDTH-1:0] dataOut,
    output logic                  fifoFull,
    output logic                  fifoEmpty,
    output logic                  almostFull,
    output logic                  almostEmpty,
    output logic [ADDR_WIDTH:0]   numElementsInFifo,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(32'd1);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] mem_count_q, mem_count_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                af_q, af_d;
    logic                ae_q, ae_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                mem_rd_s;
    logic                wr_acc_s;
    logic                mem_we_s;
    logic                mem_re_s;
    logic                ovf_set_s;
    logic                unf_set_s;

`ifdef SYNC_FIFO_FWFT_EN
    logic ovalid_q, ovalid_d;
    logic mem_empty_s;
    logic user_pop_s;

    // Prefetch from memory whenever the output register is free or being popped.
    assign mem_empty_s = (mem_count_q == '0);
    assign user_pop_s  = fifoREn & ovalid_q;
    assign mem_rd_s    = ~mem_empty_s & (~ovalid_q | user_pop_s);

    // Output register occupancy: filled by a prefetch, emptied by a pop or a flush.
    always_comb begin
        ovalid_d = ovalid_q;
        if (forceEmpty) begin
            ovalid_d = 1'b0;
        end else if (mem_rd_s) begin
            ovalid_d = 1'b1;
        end else if (user_pop_s) begin
            ovalid_d = 1'b0;
        end else begin
            ovalid_d = ovalid_q;
        end
    end

    // Output register valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovalid_q <= 1'b0;
        end else begin
            ovalid_q <= ovalid_d;
        end
    end

    assign count_d = mem_count_d + {{ADDR_WIDTH{1'b0}}, ovalid_d};
    assign empty_d = ~ovalid_d;
`else
    assign mem_rd_s = fifoREn & ~empty_q;
    assign count_d  = mem_count_d;
    assign empty_d  = (mem_count_d == '0);
`endif

    // A full FIFO still takes a write when a word leaves memory in the same cycle.
    assign wr_acc_s  = fifoWEn & (~full_q | mem_rd_s);
    assign mem_we_s  = wr_acc_s & ~forceEmpty;
    assign mem_re_s  = mem_rd_s & ~forceEmpty;
    assign ovf_set_s = fifoWEn & ~wr_acc_s & ~forceEmpty;
    assign unf_set_s = fifoREn & empty_q & ~forceEmpty;

    // Pointer and memory occupancy next state; a flush overrides any traffic.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_count_d = mem_count_q;
        if (forceEmpty) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            mem_count_d = '0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + ONE_C;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (mem_rd_s) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_acc_s, mem_rd_s})
                2'b10:   mem_count_d = mem_count_q + ONE_C;
                2'b01:   mem_count_d = mem_count_q - ONE_C;
                default: mem_count_d = mem_count_q;
            endcase
        end
    end

    // Status flags from the next occupancy; sticky errors where a new error beats a clear.
    always_comb begin
        full_d = (mem_count_d == DEPTH_C);
        af_d   = 1'b0;
        ae_d   = 1'b0;
        if (afThresh == '0) begin
            af_d = 1'b1;
        end else begin
            af_d = (count_d >= afThresh);
        end
        if (aeThresh >= DEPTH_C) begin
            ae_d = 1'b1;
        end else begin
            ae_d = (count_d <= aeThresh);
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (clrErr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (unf_set_s) begin
            unf_d = 1'b1;
        end else if (clrErr) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    dpMem_sc #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we_s),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (dataIn),
        .re_i    (mem_re_s),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (dataOut)
    );

    assign fifoFull          = full_q;
    assign fifoEmpty         = empty_q;
    assign almostFull        = af_q;
    assign almostEmpty       = ae_q;
    assign numElementsInFifo = count_q;
    assign overflow          = ovf_q;
    assign underflow         = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised self-checking bench for sync_fifo_param (standard read mode),
// compared against a queue-based reference model.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       fifoWEn = 1'b0;
    logic       fifoREn = 1'b0;
    logic       forceEmpty = 1'b0;
    logic [6:0] afThresh = 7'd56;
    logic [6:0] aeThresh = 7'd4;
    logic       clrErr = 1'b0;
    logic [7:0] dataOut;
    logic       fifoFull, fifoEmpty, almostFull, almostEmpty, overflow, underflow;
    logic [6:0] numElementsInFifo;

    sync_fifo_param dut (
        .clk (clk), .rst (rst), .dataIn (dataIn), .fifoWEn (fifoWEn),
        .fifoREn (fifoREn), .forceEmpty (forceEmpty), .afThresh (afThresh),
        .aeThresh (aeThresh), .clrErr (clrErr), .dataOut (dataOut),
        .fifoFull (fifoFull), .fifoEmpty (fifoEmpty), .almostFull (almostFull),
        .almostEmpty (almostEmpty), .numElementsInFifo (numElementsInFifo),
        .overflow (overflow), .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    int         acc_rd = 0;
    int         acc_wr = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    localparam logic [12:0] RESET_STATUS = 13'b0_1_0_1_0_0_0000000;

    function automatic logic [12:0] dut_status();
        return {fifoFull, fifoEmpty, almostFull, almostEmpty, overflow, underflow, numElementsInFifo};
    endfunction

    function automatic logic [12:0] exp_status();
        int  n;
        logic f, e, a, ae;
        n  = mq.size();
        f  = (n == 64);
        e  = (n == 0);
        a  = (afThresh == 7'd0) || (n >= int'(afThresh));
        ae = (aeThresh >= 7'd64) || (n <= int'(aeThresh));
        return {f, e, a, ae, m_ovf, m_unf, 7'(n)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input logic we, input logic re, input logic [7:0] din,
                         input logic fe, input logic clr);
        int   n;
        logic rd, wr, sov, sun;
        fifoWEn = we; fifoREn = re; dataIn = din; forceEmpty = fe; clrErr = clr;
        n = mq.size();
        sov = 1'b0; sun = 1'b0;
        if (fe) begin
            mq.delete();
        end else begin
            rd  = re && (n > 0);
            wr  = we && ((n < 64) || rd);
            sov = we && !wr;
            sun = re && (n == 0);
            if (rd) begin m_dout = mq.pop_front(); acc_rd++; end
            if (wr) begin mq.push_back(din); acc_wr++; end
        end
        m_ovf = sov ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = sun ? 1'b1 : (clr ? 1'b0 : m_unf);
        @(posedge clk);
        #1;
        fifoWEn = 1'b0; fifoREn = 1'b0; forceEmpty = 1'b0; clrErr = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (dut_status() !== RESET_STATUS) begin n_fail++; $display("FAIL reset_status: got %b expected %b", dut_status(), RESET_STATUS); end
        n_checks++;
        if (dataOut !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", dataOut); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (dut_status() !== RESET_STATUS) begin n_fail++; $display("FAIL reset_release: got %b expected %b", dut_status(), RESET_STATUS); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 64; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
            n_checks++;
            if (dut_status() !== exp_status()) begin n_fail++; $display("FAIL fill_status[%0d]: got %b expected %b", i, dut_status(), exp_status()); end
        end
        n_checks++;
        if ({fifoFull, numElementsInFifo} !== {1'b1, 7'd64}) begin n_fail++; $display("FAIL fill_full: got %b/%0d expected 1/64", fifoFull, numElementsInFifo); end
        cycle(1'b1, 1'b0, 8'h41, 1'b0, 1'b0);
        n_checks++;
        if ({overflow, numElementsInFifo} !== {1'b1, 7'd64}) begin n_fail++; $display("FAIL overflow_65th: got %b/%0d expected 1/64", overflow, numElementsInFifo); end
    endtask

    task automatic test_full_rw();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
        cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        n_checks++;
        if ({fifoFull, overflow, numElementsInFifo} !== {1'b1, 1'b0, 7'd64}) begin n_fail++; $display("FAIL full_rw: got %b%b/%0d expected 10/64", fifoFull, overflow, numElementsInFifo); end
        n_checks++;
        if (dataOut !== 8'h01) begin n_fail++; $display("FAIL full_rw_dout: got %h expected 01", dataOut); end
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if ({dataOut, dut_status()} !== {m_dout, exp_status()}) begin n_fail++; $display("FAIL drain[%0d]: got %h/%b expected %h/%b", i, dataOut, dut_status(), m_dout, exp_status()); end
        end
        n_checks++;
        if (dataOut !== 8'hAA) begin n_fail++; $display("FAIL last_word: got %h expected AA", dataOut); end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({underflow, dataOut} !== {1'b1, 8'hAA}) begin n_fail++; $display("FAIL underflow_set: got %b/%h expected 1/AA", underflow, dataOut); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clr: got %b expected 0", underflow); end
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr: got %b expected 1", underflow); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (dut_status() !== exp_status()) begin n_fail++; $display("FAIL after_clr: got %b expected %b", dut_status(), exp_status()); end
    endtask

    task automatic test_thresholds();
        afThresh = 7'd48;
        aeThresh = 7'd8;
        for (int i = 1; i <= 48; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
            n_checks++;
            if (dut_status() !== exp_status()) begin n_fail++; $display("FAIL thr_fill[%0d]: got %b expected %b", i, dut_status(), exp_status()); end
            if (i == 47) begin
                n_checks++;
                if (almostFull !== 1'b0) begin n_fail++; $display("FAIL af_at_47: got %b expected 0", almostFull); end
            end
        end
        n_checks++;
        if (almostFull !== 1'b1) begin n_fail++; $display("FAIL af_at_48: got %b expected 1", almostFull); end
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if ({dataOut, dut_status()} !== {m_dout, exp_status()}) begin n_fail++; $display("FAIL thr_drain[%0d]: got %h/%b expected %h/%b", i, dataOut, dut_status(), m_dout, exp_status()); end
            if (i == 39) begin
                n_checks++;
                if (almostEmpty !== 1'b0) begin n_fail++; $display("FAIL ae_at_9: got %b expected 0", almostEmpty); end
            end
        end
        n_checks++;
        if ({almostEmpty, numElementsInFifo} !== {1'b1, 7'd8}) begin n_fail++; $display("FAIL ae_at_8: got %b/%0d expected 1/8", almostEmpty, numElementsInFifo); end
    endtask

    task automatic test_random_wrap();
        int   wr0, rd0, cyc;
        logic we, re;
        wr0 = acc_wr; rd0 = acc_rd; cyc = 0;
        while (((acc_wr - wr0) < 100 || (acc_rd - rd0) < 100) && cyc < 3000) begin
            we = ((acc_wr - wr0) < 100) && ($urandom_range(0, 1) == 1);
            re = ((acc_rd - rd0) < 100) && ($urandom_range(0, 1) == 1);
            cycle(we, re, 8'($urandom), 1'b0, 1'b0);
            cyc++;
            n_checks++;
            if ({dataOut, dut_status()} !== {m_dout, exp_status()}) begin n_fail++; $display("FAIL random[%0d]: got %h/%b expected %h/%b", cyc, dataOut, dut_status(), m_dout, exp_status()); end
        end
        n_checks++;
        if (cyc >= 3000) begin n_fail++; $display("FAIL random_budget: got %0d cycles expected < 3000", cyc); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_thresh_bounds();
        afThresh = 7'd0;
        aeThresh = 7'd64;
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({almostFull, almostEmpty} !== 2'b11) begin n_fail++; $display("FAIL thr_bounds: got %b expected 11", {almostFull, almostEmpty}); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({almostFull, almostEmpty} !== 2'b11) begin n_fail++; $display("FAIL thr_bounds_empty: got %b expected 11", {almostFull, almostEmpty}); end
        afThresh = 7'd48;
        aeThresh = 7'd8;
    endtask

    task automatic test_force_empty();
        logic [7:0] hold;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        end
        n_checks++;
        if (dut_status() !== exp_status()) begin n_fail++; $display("FAIL fe_fill: got %b expected %b", dut_status(), exp_status()); end
        hold = dataOut;
        cycle(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
        n_checks++;
        if ({fifoEmpty, numElementsInFifo, dataOut} !== {1'b1, 7'd0, m_dout}) begin n_fail++; $display("FAIL force_empty: got %b/%0d/%h expected 1/0/%h", fifoEmpty, numElementsInFifo, dataOut, m_dout); end
        n_checks++;
        if (dataOut !== hold) begin n_fail++; $display("FAIL fe_dout_hold: got %h expected %h", dataOut, hold); end
        cycle(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({dataOut, dut_status()} !== {8'h33, exp_status()}) begin n_fail++; $display("FAIL fe_discard: got %h/%b expected 33/%b", dataOut, dut_status(), exp_status()); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, (i > 5), 8'($urandom), 1'b0, 1'b0);
        end
        n_checks++;
        if ({dataOut, dut_status()} !== {m_dout, exp_status()}) begin n_fail++; $display("FAIL pre_rst: got %h/%b expected %h/%b", dataOut, dut_status(), m_dout, exp_status()); end
        fifoWEn = 1'b1; dataIn = 8'h77;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({dataOut, dut_status()} !== {8'h00, RESET_STATUS}) begin n_fail++; $display("FAIL async_rst: got %h/%b expected 00/%b", dataOut, dut_status(), RESET_STATUS); end
        #2 rst = 1'b0;
        fifoWEn = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({dataOut, dut_status()} !== {8'h00, RESET_STATUS}) begin n_fail++; $display("FAIL post_rst: got %h/%b expected 00/%b", dataOut, dut_status(), RESET_STATUS); end
        cycle(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({dataOut, dut_status()} !== {8'hC3, exp_status()}) begin n_fail++; $display("FAIL post_rst_rw: got %h/%b expected C3/%b", dataOut, dut_status(), exp_status()); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_full_rw();
        test_underflow();
        test_thresholds();
        test_random_wrap();
        test_thresh_bounds();
        test_force_empty();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
